// File: rtl/tag_lookup_if.sv
// Bundle of request, tag array, comparator, response and statistics signals
// shared by the tag lookup sequencer and its surroundings.
interface tag_lookup_if #(
    parameter int ADDRESS_BITS = 32,
    parameter int INDEX_BITS   = 14,
    parameter int OFFSET_BITS  = 6,
    parameter int WAYS         = 8
) ();
    localparam int TAG_BITS = ADDRESS_BITS - INDEX_BITS - OFFSET_BITS;
    localparam int WAY_BITS = $clog2(WAYS);

    logic                    reqValid;
    logic [ADDRESS_BITS-1:0] reqAddress;
    logic                    reqReady;
    logic                    tagRdEn;
    logic [INDEX_BITS-1:0]   tagRdSet;
    logic [WAY_BITS-1:0]     tagRdWay;
    logic [TAG_BITS-1:0]     tagRdData;
    logic                    tagRdValid;
    logic [TAG_BITS-1:0]     cmpAddressTag;
    logic [TAG_BITS-1:0]     cmpCacheTag;
    logic                    cmpMatch;
    logic                    respValid;
    logic                    respReady;
    logic                    respHit;
    logic [WAY_BITS-1:0]     respWay;
    logic                    respFreeValid;
    logic [WAY_BITS-1:0]     respFreeWay;
    logic [31:0]             hitCount;
    logic [31:0]             missCount;

    // Environment side: requester, tag array, comparator, consumer.
    modport master (
        output reqValid, reqAddress, tagRdData, tagRdValid, cmpMatch, respReady,
        input  reqReady, tagRdEn, tagRdSet, tagRdWay, cmpAddressTag, cmpCacheTag,
               respValid, respHit, respWay, respFreeValid, respFreeWay, hitCount, missCount
    );

    // Sequencer side.
    modport slave (
        input  reqValid, reqAddress, tagRdData, tagRdValid, cmpMatch, respReady,
        output reqReady, tagRdEn, tagRdSet, tagRdWay, cmpAddressTag, cmpCacheTag,
               respValid, respHit, respWay, respFreeValid, respFreeWay, hitCount, missCount
    );
endinterface

// File: rtl/tag_lookup_sequencer.sv
// L2 tag check front end: walks the ways of one set serially, one read plus
// one compare per way, and reports hit way or the lowest free way on a miss.
//
// state | meaning
// IDLE  | ready for a lookup, nothing latched in use
// READ  | tag array read strobe for way way_cnt
// CMP   | stored tag/valid of way way_cnt at the comparator
// RESP  | result held until the consumer accepts it
module tag_lookup_sequencer #(
    parameter int ADDRESS_BITS = 32,
    parameter int INDEX_BITS   = 14,
    parameter int OFFSET_BITS  = 6,
    parameter int WAYS         = 8
) (
    input logic         clk,
    input logic         rst_n,
    tag_lookup_if.slave bus
);
    localparam int TAG_BITS = ADDRESS_BITS - INDEX_BITS - OFFSET_BITS;
    localparam int WAY_BITS = $clog2(WAYS);

    typedef enum logic [1:0] {IDLE, READ, CMP, RESP} state_t;

    state_t                state;
    state_t                state_next;
    logic [WAY_BITS-1:0]   way_cnt;
    logic [TAG_BITS-1:0]   tag_q;
    logic [INDEX_BITS-1:0] set_q;
    logic                  free_valid;
    logic [WAY_BITS-1:0]   free_way;
    logic                  hit_q;
    logic [WAY_BITS-1:0]   hit_way;
    logic [31:0]           hit_count;
    logic [31:0]           miss_count;
    logic                  accept;
    logic                  cmp_hit;
    logic                  cmp_last;
    logic                  resp_done;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode and all state-derived outputs.
    always_comb begin
        state_next         = state;
        accept             = 1'b0;
        cmp_hit            = 1'b0;
        cmp_last           = 1'b0;
        resp_done          = 1'b0;
        bus.reqReady       = 1'b0;
        bus.tagRdEn        = 1'b0;
        bus.tagRdSet       = '0;
        bus.tagRdWay       = '0;
        bus.cmpAddressTag  = '0;
        bus.cmpCacheTag    = '0;
        bus.respValid      = 1'b0;
        bus.respHit        = 1'b0;
        bus.respWay        = '0;
        bus.respFreeValid  = 1'b0;
        bus.respFreeWay    = '0;
        case (state)
            IDLE: begin
                bus.reqReady = 1'b1;
                if (bus.reqValid) begin
                    accept     = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                bus.tagRdEn       = 1'b1;
                bus.tagRdSet      = set_q;
                bus.tagRdWay      = way_cnt;
                bus.cmpAddressTag = tag_q;
                state_next        = CMP;
            end
            CMP: begin
                bus.cmpAddressTag = tag_q;
                bus.cmpCacheTag   = bus.tagRdData;
                // A matching tag on an invalid line must not count as a hit.
                if (bus.tagRdValid && bus.cmpMatch) begin
                    cmp_hit    = 1'b1;
                    state_next = RESP;
                end else if (way_cnt == WAY_BITS'(WAYS - 1)) begin
                    cmp_last   = 1'b1;
                    state_next = RESP;
                end else begin
                    state_next = READ;
                end
            end
            RESP: begin
                bus.cmpAddressTag = tag_q;
                bus.respValid     = 1'b1;
                bus.respHit       = hit_q;
                bus.respWay       = hit_q ? hit_way : '0;
                bus.respFreeValid = !hit_q && free_valid;
                bus.respFreeWay   = (!hit_q && free_valid) ? free_way : '0;
                if (bus.respReady) begin
                    resp_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Lookup context, scan progress, result and saturating statistics.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            way_cnt    <= '0;
            tag_q      <= '0;
            set_q      <= '0;
            free_valid <= 1'b0;
            free_way   <= '0;
            hit_q      <= 1'b0;
            hit_way    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (accept) begin
                tag_q      <= bus.reqAddress[ADDRESS_BITS-1 -: TAG_BITS];
                set_q      <= bus.reqAddress[OFFSET_BITS +: INDEX_BITS];
                way_cnt    <= '0;
                free_valid <= 1'b0;
                free_way   <= '0;
                hit_q      <= 1'b0;
                hit_way    <= '0;
            end
            if (state == CMP) begin
                if (!bus.tagRdValid && !free_valid) begin
                    free_valid <= 1'b1;
                    free_way   <= way_cnt;
                end
                if (cmp_hit) begin
                    hit_q   <= 1'b1;
                    hit_way <= way_cnt;
                end else if (!cmp_last) begin
                    way_cnt <= way_cnt + WAY_BITS'(1);
                end
            end
            if (resp_done) begin
                if (hit_q) begin
                    if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
                end else begin
                    if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
                end
            end
        end
    end

    assign bus.hitCount  = hit_count;
    assign bus.missCount = miss_count;
endmodule
